// File: rtl/exec_wb_pkg.sv
// exec_wb_pkg: opcodes, RF entry layout and print FSM states shared by the execute/writeback slice
package exec_wb_pkg;
  localparam int ENT_W   = 35;
  localparam int VAL_LSB = 0;
  localparam int TAG_LSB = 16;
  localparam int LOCK_B  = 32;
  localparam int RETR_B  = 33;
  localparam int VALID_B = 34;
  localparam logic [3:0] OP_PLUS  = 4'h1;
  localparam logic [3:0] OP_MINUS = 4'h2;
  localparam logic [3:0] OP_BRZ   = 4'h5;
  localparam logic [3:0] OP_PRINT = 4'h9;
  localparam logic [3:0] OP_END   = 4'hA;
  typedef enum logic {P_IDLE, P_WAIT} print_st_t;
endpackage

// File: rtl/exec_wb_rf_write.sv
// rf_write: rewrites one RF entry's value and clears its lock, passing every other bit through
module rf_write
  import exec_wb_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int IDX_W  = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic [IDX_W-1:0]        idx,
  input  logic [15:0]             wr_val,
  input  logic                    en,
  input  logic [NCORES*ENT_W-1:0] bus_in,
  output logic [NCORES*ENT_W-1:0] bus_out
);
  always_comb begin
    bus_out = bus_in;
    if (en) begin
      bus_out[idx*ENT_W+VAL_LSB +: 16] = wr_val;
      bus_out[idx*ENT_W+LOCK_B]        = 1'b0;
    end
  end
endmodule

// File: rtl/exec_wb.sv
// exec_wb: execute/writeback stage - ALU writeback into the shared RF, BRZ resolve, print handshake, halt and retire count
module exec_wb
  import exec_wb_pkg::*;
#(
  parameter int NCORES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             ins,
  input  logic [15:0]             val,
  input  logic [15:0]             ptr,
  input  logic [NCORES*ENT_W-1:0] rf_in,
  output logic [NCORES*ENT_W-1:0] rf_out,
  output logic                    branch_en,
  output logic [15:0]             branch_target,
  output logic                    print_valid,
  output logic [7:0]              print_data,
  input  logic                    print_ready,
  output logic                    hold,
  output logic                    halted,
  output logic [15:0]             retired
);
  localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;
  logic [15:0] ins_q, val_q, ptr_q;
  logic [3:0] op;
  logic [11:0] imm;
  logic is_alu, hit, wb_en, wb_miss;
  logic [IDX_W-1:0] idx;
  logic [15:0] wb_val;
  print_st_t st, st_nx;
  assign op     = ins_q[15:12];
  assign imm    = ins_q[11:0];
  assign is_alu = (op == OP_PLUS || op == OP_MINUS) && !halted;
  assign wb_en  = is_alu && hit;
  assign wb_val = (op == OP_PLUS) ? val_q + {4'h0, imm} : val_q - {4'h0, imm};
  assign branch_en     = (op == OP_BRZ) && (val_q == 16'h0) && !halted;
  assign branch_target = branch_en ? {4'h0, imm} : 16'h0;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NCORES - 1; i >= 0; i--)
      if (rf_in[i*ENT_W+VALID_B] && rf_in[i*ENT_W+LOCK_B] && rf_in[i*ENT_W+TAG_LSB +: 16] == ptr_q) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
  end
  rf_write #(.NCORES(NCORES), .IDX_W(IDX_W)) u_rf_write (
    .idx(idx), .wr_val(wb_val), .en(wb_en), .bus_in(rf_in), .bus_out(rf_out)
  );
  always_comb begin
    print_valid = (st == P_WAIT) || (op == OP_PRINT && !halted);
    hold        = print_valid && !print_ready;
    st_nx       = hold ? P_WAIT : P_IDLE;
    print_data  = print_valid ? val_q[7:0] : 8'h0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ins_q   <= '0;
      val_q   <= '0;
      ptr_q   <= '0;
      st      <= P_IDLE;
      halted  <= 1'b0;
      retired <= '0;
      wb_miss <= 1'b0;
    end else begin
      if (!hold) begin
        ins_q <= halted ? 16'h0 : ins;
        val_q <= val;
        ptr_q <= ptr;
      end
      st <= st_nx;
      if (op == OP_END) halted <= 1'b1;
      if (ins_q != 16'h0 && !hold && !halted) retired <= retired + 16'h1;
      if (is_alu && !hit) wb_miss <= 1'b1;
    end
  end
  a_no_wb_miss: assert property (@(posedge clk) disable iff (!rst_n) !wb_miss);
endmodule

// File: tb/tb_exec_wb.sv
// tb_exec_wb: directed vectors with hand-computed expectations for exec_wb
module tb_exec_wb;
  localparam int NC = 4;
  localparam int W  = NC * 35;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] ins = '0, val = '0, ptr = '0;
  logic [W-1:0] rf_in = '0, rf_out, exp_rf;
  logic branch_en, print_valid, hold, halted, print_ready = 1'b1;
  logic [15:0] branch_target, retired;
  logic [7:0] print_data;
  int n_chk = 0, n_fail = 0;
  exec_wb #(.NCORES(NC)) dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .val(val), .ptr(ptr),
    .rf_in(rf_in), .rf_out(rf_out),
    .branch_en(branch_en), .branch_target(branch_target),
    .print_valid(print_valid), .print_data(print_data), .print_ready(print_ready),
    .hold(hold), .halted(halted), .retired(retired)
  );
  always #5 clk = ~clk;
  function automatic logic [34:0] ent(logic v, logic r, logic l, logic [15:0] t, logic [15:0] d);
    return {v, r, l, t, d};
  endfunction
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rf_in[0*35 +: 35] = ent(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    rf_in[1*35 +: 35] = ent(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234);
    rf_in[2*35 +: 35] = ent(1'b1, 1'b1, 1'b1, 16'h0010, 16'h0005);
    rf_in[3*35 +: 35] = ent(1'b1, 1'b0, 1'b1, 16'h0020, 16'h7777);
    step();
    step();
    check("rst_rf", rf_out, rf_in);
    check("rst_br", branch_en, 0);
    check("rst_bt", branch_target, 0);
    check("rst_pv", print_valid, 0);
    check("rst_pd", print_data, 0);
    check("rst_hold", hold, 0);
    check("rst_halt", halted, 0);
    check("rst_ret", retired, 0);
    rst_n = 1'b1;
    ins = 16'h1003; val = 16'h0005; ptr = 16'h0010;
    step();
    exp_rf = rf_in;
    exp_rf[2*35 +: 35] = ent(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0008);
    check("plus_wb", rf_out, exp_rf);
    ins = 16'h0; val = 16'h0; ptr = 16'h0;
    step();
    check("plus_ret", retired, 1);
    check("bubble_rf", rf_out, rf_in);
    ins = 16'h2001; val = 16'h0000; ptr = 16'h0020;
    step();
    exp_rf = rf_in;
    exp_rf[1*35 +: 35] = ent(1'b1, 1'b0, 1'b0, 16'h0020, 16'hFFFF);
    check("minus_wrap", rf_out, exp_rf);
    ins = 16'h0;
    step();
    check("minus_ret", retired, 2);
    ins = 16'h5040; val = 16'h0000;
    step();
    check("brz_en", branch_en, 1);
    check("brz_tgt", branch_target, 16'h0040);
    ins = 16'h0;
    step();
    check("brz_once", branch_en, 0);
    check("brz_tgt0", branch_target, 0);
    check("brz_ret", retired, 3);
    ins = 16'h5040; val = 16'h0001;
    step();
    check("brnz_en", branch_en, 0);
    check("brnz_tgt", branch_target, 0);
    ins = 16'h0;
    step();
    check("brnz_ret", retired, 4);
    ins = 16'h9000; val = 16'h0041; print_ready = 1'b0;
    step();
    ins = 16'h0; val = 16'h0;
    for (int c = 0; c < 3; c++) begin
      check("pr_valid", print_valid, 1);
      check("pr_data", print_data, 8'h41);
      check("pr_hold", hold, 1);
      check("pr_ret_wait", retired, 4);
      if (c < 2) step();
      else begin
        @(posedge clk);
        #1;
      end
    end
    print_ready = 1'b1;
    #1;
    check("pr_acc_valid", print_valid, 1);
    check("pr_acc_data", print_data, 8'h41);
    check("pr_acc_hold", hold, 0);
    step();
    check("pr_done_valid", print_valid, 0);
    check("pr_ret", retired, 5);
    step();
    check("pr_ret_once", retired, 5);
    ins = 16'hA000;
    step();
    ins = 16'h1003; val = 16'h0005; ptr = 16'h0010;
    step();
    check("end_halt", halted, 1);
    check("end_ret", retired, 6);
    check("halt_nowb", rf_out, rf_in);
    ins = 16'h5040; val = 16'h0000;
    step();
    check("halt_nowb2", rf_out, rf_in);
    check("halt_nobr", branch_en, 0);
    step();
    check("halt_ret", retired, 6);
    rst_n = 1'b0; ins = 16'h0;
    step();
    rst_n = 1'b1;
    check("rst_unhalt", halted, 0);
    ins = 16'h1003; val = 16'h0005; ptr = 16'h0010;
    step();
    ins = 16'h9000; val = 16'h0041; print_ready = 1'b0;
    step();
    step();
    check("wait_valid", print_valid, 1);
    check("wait_ret", retired, 1);
    rst_n = 1'b0;
    step();
    check("rstw_valid", print_valid, 0);
    check("rstw_data", print_data, 0);
    check("rstw_hold", hold, 0);
    check("rstw_halt", halted, 0);
    check("rstw_ret", retired, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_wb.md
Name: exec_wb

Overview:
- Per-core execute/writeback stage, directly downstream of the operand-select stage.
- Consumes the filtered instruction (squashed to 16'h0000 on stall/branch) and the operand value.
- Computes PLUS/MINUS results, writes them into the shared register file and unlocks the entry.
- Resolves BRZ, drives the PRINT output handshake, flags END, and counts retired instructions.

Parameters:
- NCORES, 4, register-file entries; the shared RF bus is NCORES*35 bits.
- ENT_W, 35, width of one RF entry {valid, retr, locked, tag[15:0], val[15:0]}; fixed, not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- ins  in  16  instruction from select; [15:12] opcode, [11:0] imm; 16'h0000 is a bubble.
- val  in  16  operand value from select.
- ptr  in  16  data pointer (RF tag) of ins.
- rf_in  in  NCORES*35  shared RF chain input.
- rf_out  out  NCORES*35  shared RF chain output.
- branch_en  out  1  BRZ taken.
- branch_target  out  16  {4'h0, imm} of the taken BRZ.
- print_valid  out  1  print data valid.
- print_data  out  8  character to print.
- print_ready  in  1  sink accepts print_data.
- hold  out  1  upstream must freeze ins/val/ptr.
- halted  out  1  sticky, END retired.
- retired  out  16  retired-instruction counter.

Behaviour:
- Opcodes: PLUS=1, MINUS=2, BRZ=5, PRINT=9, END=A. Every other opcode, including 0, is a no-op.
- E register (ins_q, val_q, ptr_q):
  - On !rst_n: all cleared.
  - Else if !hold: captures ins/val/ptr.
  - Else: holds its value.
  - One cycle latency from select to the E-stage effects.
- Writeback (combinational from E) applies when ins_q is PLUS/MINUS and !halted:
  - Target is the lowest index i with valid & locked & tag==ptr_q.
  - rf_out[i].val = val_q + imm (PLUS) or val_q - imm (MINUS); imm is zero-extended; result is mod 2^16.
  - rf_out[i].locked = 0. All other fields and entries pass rf_in through unchanged.
  - No match: rf_out = rf_in and sticky internal wb_miss is set. wb_miss is for assertions only and is cleared by reset.
- Branch: branch_en = (op==BRZ) & (val_q==0) & !halted, combinational from E, so it is high for exactly the one cycle BRZ sits in E. branch_target = {4'h0, ins_q[11:0]}. When branch_en=0, branch_target=0.
- Print FSM, states IDLE/WAIT; reset -> IDLE.
  - IDLE, op==PRINT: print_valid=1, print_data=val_q[7:0]. If print_ready, stay IDLE; else -> WAIT.
  - WAIT: print_valid=1 and print_data stays stable; on print_ready -> IDLE.
  - hold = (IDLE & op==PRINT & !print_ready) | WAIT.
  - Reset in WAIT: print_valid drops the same edge and the character is discarded.
- END: halted<=1 when op==END is in E; stays set until reset. While halted, E captures nothing (forced bubble) and no outputs fire.
- retired:
  - Increments when ins_q!=0 && !hold && !halted.
  - END increments it once.
  - A PRINT counts only on its accepted cycle.
  - Wraps FFFF->0000. Reset value 0.
- Reset values: rf_out=rf_in (pass-through), branch_en=0, branch_target=0, print_valid=0, print_data=0, hold=0, halted=0, retired=0.
- Simultaneous events:
  - A PLUS/MINUS never coexists with a PRINT in E, so writeback occurs exactly once per instruction even across hold.
  - When select squashes the post-branch slot, E sees bubbles.

Decomposition:
- Shared package: opcode constants (also used by select), ENT_W, entry field offsets, print FSM state enum.
- One sub-module, rf_write: takes the entry index, new val, a clear-lock enable and the RF bus, and returns the modified bus. It is the write counterpart of rf_read.

Test Plan:
- RF entry 2 {v=1,l=1,tag=0x0010,val=5}; PLUS imm=3 ptr=0x0010 val=5 -> next cycle rf_out entry2 val=8, locked=0; retired=1.
- MINUS imm=1 with val=0x0000 -> written val=0xFFFF (wrap); entry unlocked.
- BRZ imm=0x040, val=0 -> branch_en=1 for exactly one cycle, branch_target=0x0040. Same with val=1 -> branch_en stays 0.
- PRINT val=0x0041, print_ready low for 3 cycles -> print_valid=1, print_data=0x41 stable, hold=1 for 3 cycles; accepted on the 4th; retired +1 once.
- END then PLUS -> halted=1, the PLUS is never written back, retired stops incrementing. rst_n=0 during a PRINT WAIT -> print_valid=0, halted=0, retired=0 next edge.
